hazard_fwd_unit: RTL and testbench

Parametrised hazard-detection and forwarding unit for the 5-stage pipeline, sitting beside the ID stage and driving the operand-select muxes, the IF/ID and PC load enables, and the control-unit NOP mux. It generalises operand count and register-address width, and adds a multi-cycle load-use stall state machine, branch flush, and a stall-cycle statistics counter.

---
 rtl/hazard_fwd_unit.sv | 132 +++++++++++++
 tb/tb_hazard_fwd_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - hazard detection, operand forwarding and load-use stall control
// Optional feature macro: HAZARD_PC_GUARD_EN (all-ones register address never matches)
module hazard_fwd_unit #(
  parameter int RW       = 4,
  parameter int NSRC     = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNTW     = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [RW-1:0]       RW_EX,
  input  logic [RW-1:0]       RW_MEM,
  input  logic [RW-1:0]       RW_WB,
  input  logic [NSRC*RW-1:0]  RS_ID,
  input  logic [NSRC-1:0]     RS_VALID_ID,
  input  logic                enable_LD_EX,
  input  logic                enable_RF_EX,
  input  logic                enable_RF_MEM,
  input  logic                enable_RF_WB,
  input  logic                BR_TAKEN,
  output logic [2*NSRC-1:0]   IS,
  output logic                C_Unit_MUX,
  output logic                HZld,
  output logic                IF_ID_ld,
  output logic                IF_ID_flush,
  output logic [CNTW-1:0]     STALL_CYCLES
);

`ifdef HAZARD_PC_GUARD_EN
  localparam logic PC_GUARD = 1'b1;
`else
  localparam logic PC_GUARD = 1'b0;
`endif

  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

  typedef enum logic {S_IDLE, S_STALL} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_cnt;
  logic [2:0]      w_cnt_nxt;
  logic [CNTW-1:0] r_stall_cycles;
  logic            w_stall;
  logic            w_hazard;

  logic [RW-1:0]   w_rs [NSRC];
  logic [NSRC-1:0] w_ok;
  logic [NSRC-1:0] w_m_ex;
  logic [NSRC-1:0] w_m_mem;
  logic [NSRC-1:0] w_m_wb;
  logic [1:0]      w_sel [NSRC];

  // Per-source stage matching and priority forwarding select (EX > MEM > WB > RF)
  for (genvar g = 0; g < NSRC; g++) begin : g_src
    assign w_rs[g]    = RS_ID[g*RW +: RW];
    assign w_ok[g]    = RS_VALID_ID[g] & ~(PC_GUARD & (&w_rs[g]));
    assign w_m_ex[g]  = w_ok[g] & enable_RF_EX  & (w_rs[g] == RW_EX);
    assign w_m_mem[g] = w_ok[g] & enable_RF_MEM & (w_rs[g] == RW_MEM);
    assign w_m_wb[g]  = w_ok[g] & enable_RF_WB  & (w_rs[g] == RW_WB);
    // Load result is not available in EX yet, so an EX match on a load falls through
    assign w_sel[g]   = (w_m_ex[g] & ~enable_LD_EX) ? 2'b01 :
                        w_m_mem[g]                  ? 2'b10 :
                        w_m_wb[g]                   ? 2'b11 : 2'b00;
    assign IS[2*g +: 2] = RST_N ? w_sel[g] : 2'b00;
  end

  assign w_hazard = enable_LD_EX & (|w_m_ex);

  // Stall FSM next-state and stall decision; taken branch overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    if (BR_TAKEN) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hazard) begin
            w_stall = 1'b1;
            if (LOAD_LAT > 1) begin
              w_state_nxt = S_STALL;
              w_cnt_nxt   = LAT_M1;
            end
          end
        end
        S_STALL: begin
          w_stall = 1'b1;
          if (r_cnt <= 3'd1) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 3'd0;
          end else begin
            w_cnt_nxt   = r_cnt - 3'd1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  // FSM state and remaining-stall counter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Saturating count of cycles in which the pipeline front end was held
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != {CNTW{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign C_Unit_MUX   = ~(w_stall & RST_N);
  assign HZld         = ~(w_stall & RST_N);
  assign IF_ID_ld     = ~(w_stall & RST_N);
  assign IF_ID_flush  = BR_TAKEN & RST_N;
  assign STALL_CYCLES = r_stall_cycles;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - randomized and directed self-check of hazard_fwd_unit against a behavioural model
module tb_hazard_fwd_unit;

`ifdef HAZARD_PC_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  rw_ex, rw_mem, rw_wb;
  logic [11:0] rs_id;
  logic [2:0]  rs_v;
  logic        ld_ex, rf_ex, rf_mem, rf_wb, br;

  logic [5:0]  is1, is3;
  logic        cu1, hz1, ld1, fl1;
  logic        cu3, hz3, ld3, fl3;
  logic [15:0] sc1;
  logic [3:0]  sc3;

  int n_vec = 0;
  int n_err = 0;
  int rem [2];
  int cnt [2];
  int lat [2]  = '{1, 3};
  int cmax [2] = '{65535, 15};

  always #5 CLK = ~CLK;

  hazard_fwd_unit #(.RW(4), .NSRC(3), .LOAD_LAT(1), .CNTW(16)) u_d1 (
    .CLK(CLK), .RST_N(RST_N), .RW_EX(rw_ex), .RW_MEM(rw_mem), .RW_WB(rw_wb),
    .RS_ID(rs_id), .RS_VALID_ID(rs_v), .enable_LD_EX(ld_ex), .enable_RF_EX(rf_ex),
    .enable_RF_MEM(rf_mem), .enable_RF_WB(rf_wb), .BR_TAKEN(br), .IS(is1),
    .C_Unit_MUX(cu1), .HZld(hz1), .IF_ID_ld(ld1), .IF_ID_flush(fl1), .STALL_CYCLES(sc1)
  );

  hazard_fwd_unit #(.RW(4), .NSRC(3), .LOAD_LAT(3), .CNTW(4)) u_d3 (
    .CLK(CLK), .RST_N(RST_N), .RW_EX(rw_ex), .RW_MEM(rw_mem), .RW_WB(rw_wb),
    .RS_ID(rs_id), .RS_VALID_ID(rs_v), .enable_LD_EX(ld_ex), .enable_RF_EX(rf_ex),
    .enable_RF_MEM(rf_mem), .enable_RF_WB(rf_wb), .BR_TAKEN(br), .IS(is3),
    .C_Unit_MUX(cu3), .HZld(hz3), .IF_ID_ld(ld3), .IF_ID_flush(fl3), .STALL_CYCLES(sc3)
  );

  function automatic int src(int i);
    return int'((rs_id >> (4 * i)) & 12'hF);
  endfunction

  function automatic bit usable(int i);
    return rs_v[i] && !(GUARD && src(i) == 15);
  endfunction

  function automatic logic [5:0] model_is();
    logic [5:0] r = '0;
    for (int i = 0; i < 3; i++) begin
      if (usable(i)) begin
        if (rf_ex && !ld_ex && src(i) == int'(rw_ex))  r[2*i +: 2] = 2'd1;
        else if (rf_mem && src(i) == int'(rw_mem))     r[2*i +: 2] = 2'd2;
        else if (rf_wb && src(i) == int'(rw_wb))       r[2*i +: 2] = 2'd3;
      end
    end
    if (!RST_N) r = '0;
    return r;
  endfunction

  function automatic bit model_hazard();
    bit h = 1'b0;
    for (int i = 0; i < 3; i++)
      if (usable(i) && src(i) == int'(rw_ex)) h = 1'b1;
    return h && ld_ex && rf_ex;
  endfunction

  function automatic bit model_stall(int k);
    return RST_N && !br && (rem[k] > 0 || model_hazard());
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state advance: remaining owed stall cycles and saturating stall count
  always @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (!RST_N) begin
        rem[k] = 0;
        cnt[k] = 0;
      end else begin
        bit s;
        s = model_stall(k);
        if (br)                 rem[k] = 0;
        else if (rem[k] > 0)    rem[k] = rem[k] - 1;
        else if (model_hazard()) rem[k] = lat[k] - 1;
        if (s && cnt[k] < cmax[k]) cnt[k] = cnt[k] + 1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge CLK) begin
    bit s0, s3;
    logic [5:0] e_is;
    e_is = model_is();
    s0 = model_stall(0);
    s3 = model_stall(1);
    chk("IS d1", is1, e_is);
    chk("IS d3", is3, e_is);
    chk("cunit d1", cu1, !s0);
    chk("hzld d1", hz1, !s0);
    chk("ifidld d1", ld1, !s0);
    chk("cunit d3", cu3, !s3);
    chk("hzld d3", hz3, !s3);
    chk("ifidld d3", ld3, !s3);
    chk("flush d1", fl1, RST_N && br);
    chk("flush d3", fl3, RST_N && br);
    chk("stallcnt d1", sc1, RST_N ? cnt[0] : 0);
    chk("stallcnt d3", sc3, RST_N ? cnt[1] : 0);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    rw_ex = '0; rw_mem = '0; rw_wb = '0; rs_id = '0; rs_v = '0;
    ld_ex = 0; rf_ex = 0; rf_mem = 0; rf_wb = 0; br = 0;
  endtask

  task automatic set_load_hazard(input logic [2:0] valid);
    clr();
    ld_ex = 1; rf_ex = 1; rw_ex = 4'd5; rs_id = 12'h050; rs_v = valid;
  endtask

  function automatic logic [3:0] rnd_reg();
    logic [3:0] r;
    r = 4'($urandom_range(0, 4));
    return (r == 4'd4) ? 4'hF : r;
  endfunction

  initial begin
    RST_N = 1'b0;
    clr();
    rem[0] = 0; rem[1] = 0; cnt[0] = 0; cnt[1] = 0;
    #3;
    chk("reset cunit", cu1, 1);
    chk("reset ifidld d3", ld3, 1);
    chk("reset flush", fl1, 0);
    chk("reset count", sc1, 0);
    tick(); tick();
    RST_N = 1'b1;
    tick();

    // MEM beats WB, then WB when MEM stops writing
    rs_id = 12'h003; rs_v = 3'b001; rw_mem = 4'd3; rw_wb = 4'd3; rf_mem = 1; rf_wb = 1;
    #2 chk("fwd mem", is1[1:0], 2'b10);
    rf_mem = 0;
    #1 chk("fwd wb", is1[1:0], 2'b11);
    tick();

    // Load-use hazard: one stall on LOAD_LAT=1, three on LOAD_LAT=3
    set_load_hazard(3'b010);
    #2 chk("lu1 cunit", cu1, 0);
    chk("lu1 hzld", hz1, 0);
    chk("lu1 ifidld", ld1, 0);
    chk("lu3 c1", cu3, 0);
    tick(); clr();
    #2 chk("lu1 released", cu1, 1);
    chk("lu1 count", sc1, 1);
    chk("lu3 c2", cu3, 0);
    tick();
    #2 chk("lu3 c3", cu3, 0);
    tick();
    #2 chk("lu3 released", cu3, 1);
    chk("lu3 count", sc3, 3);

    // Matching source that is not read does not stall
    set_load_hazard(3'b000);
    #2 chk("invalid src d3", cu3, 1);
    chk("invalid src d1", cu1, 1);
    tick();

    // Branch in the second stall cycle flushes and releases the stall
    set_load_hazard(3'b010);
    #2 chk("br c1", cu3, 0);
    tick(); clr(); br = 1;
    #2 chk("br flush", fl3, 1);
    chk("br cunit", cu3, 1);
    chk("br hzld", hz3, 1);
    tick(); clr();
    #2 chk("br idle", cu3, 1);
    chk("br count d3", sc3, 4);
    chk("br count d1", sc1, 2);

    // Reset while stalling
    set_load_hazard(3'b010);
    tick(); clr();
    #2 chk("mid stall", cu3, 0);
    #1 RST_N = 1'b0;
    #1 chk("rst stall cunit", cu3, 1);
    chk("rst stall ifidld", ld3, 1);
    chk("rst stall count d3", sc3, 0);
    chk("rst stall count d1", sc1, 0);
    tick();
    RST_N = 1'b1;
    tick();

    // Continuous hazard: d1 counts 20, d3 saturates at all-ones
    set_load_hazard(3'b010);
    repeat (20) tick();
    #1 chk("count 20", sc1, 20);
    chk("saturate", sc3, 4'hF);
    clr();
    repeat (4) tick();

    // All-ones register address in EX
    rw_ex = 4'hF; rs_id = 12'h00F; rs_v = 3'b001; rf_ex = 1;
    #2 chk("pc guard", is1[1:0], GUARD ? 2'b00 : 2'b01);
    tick(); clr();

    // Random phase
    repeat (3000) begin
      tick();
      RST_N  = ($urandom_range(0, 99) != 0);
      rw_ex  = rnd_reg();
      rw_mem = rnd_reg();
      rw_wb  = rnd_reg();
      rs_id  = {rnd_reg(), rnd_reg(), rnd_reg()};
      rs_v   = 3'($urandom_range(0, 7));
      ld_ex  = ($urandom_range(0, 2) == 0);
      rf_ex  = ($urandom_range(0, 3) != 0);
      rf_mem = ($urandom_range(0, 3) != 0);
      rf_wb  = ($urandom_range(0, 3) != 0);
      br     = ($urandom_range(0, 9) == 0);
    end
    tick();
    RST_N = 1'b1;
    clr();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
